minimac_rx_slots: RTL and testbench

- Parametrised successor to the minimac2 receive path. N receive slots instead of a fixed pair, with a drop counter and error and overflow abort.
- Runs entirely in the system clock domain; MII nibbles arrive qualified by a clock-enable from an upstream synchroniser.
- Detects preamble and SFD, packs nibbles into 32-bit words, writes them to a slot buffer RAM, and exposes per-slot state and count through the CSR bus.
- Raises irq_rx while any slot holds a received frame.

---
 rtl/minimac_rx_slots.sv | 199 +++++++++++++++++++
 tb/tb_minimac_rx_slots.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minimac_rx_slots.sv
// rtl/minimac_rx_slots.sv - MII receive path with N software-armed slots, drop counter and abort handling
module minimac_rx_slots #(
    parameter logic [3:0] csr_addr = 4'h0,
    parameter int NSLOTS  = 4,
    parameter int SLOT_AW = 9,
    localparam int SW = $clog2(NSLOTS),
    localparam int CW = SLOT_AW + 3
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  rx_ce,
    input  logic                  phy_dv,
    input  logic                  phy_rx_er,
    input  logic [3:0]            phy_rx_data,
    input  logic [13:0]           csr_a,
    input  logic                  csr_we,
    input  logic [31:0]           csr_di,
    output logic [31:0]           csr_do,
    output logic                  buf_we,
    output logic [SW+SLOT_AW-1:0] buf_adr,
    output logic [31:0]           buf_dat,
    output logic                  irq_rx
);

    typedef enum logic [1:0] {RX_IDLE, RX_PRE, RX_DATA, RX_DROP} rx_state_t;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_LOADED  = 2'd1;
    localparam logic [1:0] ST_PENDING = 2'd2;
    localparam logic [CW-1:0] CAP     = CW'(4) << SLOT_AW;

    rx_state_t             rx_q;
    logic [SW-1:0]         slot_q;
    logic [CW-1:0]         bcnt_q;
    logic [3:0]            nib_q;
    logic                  half_q;
    logic [31:0]           word_q;
    logic [15:0]           drop_q;
    logic [1:0]            state_q [NSLOTS];
    logic [CW-1:0]         count_q [NSLOTS];
    logic [31:0]           csr_do_q;
    logic                  buf_we_q;
    logic [SW+SLOT_AW-1:0] buf_adr_q;
    logic [31:0]           buf_dat_q;
    logic                  irq_q;

    logic        sel, csr_wr, drop_clr;
    logic [9:0]  word;
    logic        found;
    logic [SW-1:0] pick;
    logic        data_ev, sw_kill, rx_err, rx_byte, overflow, abort, finish, sfd, drop_inc;
    logic [7:0]  byte_val;
    logic [1:0]  lane;
    logic        any_pend;
    logic [31:0] rd_data;
    logic        unused_csr_di;

    assign sel      = (csr_a[13:10] == csr_addr);
    assign word     = csr_a[9:0];
    assign csr_wr   = sel && csr_we;
    assign drop_clr = csr_wr && (word == 10'(2 * NSLOTS));
    assign unused_csr_di = ^csr_di[31:2];

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NSLOTS - 1; i >= 0; i--) begin
            if (state_q[i] == ST_LOADED) begin
                found = 1'b1;
                pick  = SW'(i);
            end
        end
    end

    // A software write of EMPTY to the slot being filled cancels the frame at once, rx_ce or not.
    assign sw_kill  = (rx_q == RX_DATA) && csr_wr && (word == 10'({slot_q, 1'b0})) && (csr_di[1:0] == ST_EMPTY);
    assign data_ev  = (rx_q == RX_DATA) && rx_ce;
    assign rx_err   = data_ev && phy_dv && phy_rx_er;
    assign rx_byte  = data_ev && phy_dv && !phy_rx_er && half_q;
    assign overflow = rx_byte && (bcnt_q == CAP);
    assign abort    = sw_kill || rx_err || overflow;
    assign finish   = data_ev && !phy_dv && !sw_kill;
    assign sfd      = rx_ce && (rx_q == RX_PRE) && phy_dv && (phy_rx_data == 4'hD);
    assign drop_inc = abort || (sfd && !found);
    assign byte_val = {phy_rx_data, nib_q};
    assign lane     = bcnt_q[1:0];

    always_comb begin
        any_pend = 1'b0;
        rd_data  = 32'd0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (state_q[i] == ST_PENDING) any_pend = 1'b1;
            if (sel && word == 10'(2 * i))     rd_data = {30'd0, state_q[i]};
            if (sel && word == 10'(2 * i + 1)) rd_data = 32'(count_q[i]);
        end
        if (sel && word == 10'(2 * NSLOTS)) rd_data = {16'd0, drop_q};
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_q      <= RX_IDLE;
            slot_q    <= '0;
            bcnt_q    <= '0;
            nib_q     <= '0;
            half_q    <= 1'b0;
            word_q    <= '0;
            drop_q    <= '0;
            csr_do_q  <= '0;
            buf_we_q  <= 1'b0;
            buf_adr_q <= '0;
            buf_dat_q <= '0;
            irq_q     <= 1'b0;
            for (int i = 0; i < NSLOTS; i++) begin
                state_q[i] <= ST_EMPTY;
                count_q[i] <= '0;
            end
        end else begin
            buf_we_q <= 1'b0;
            irq_q    <= any_pend;
            csr_do_q <= rd_data;

            if (drop_clr)
                drop_q <= '0;
            else if (drop_inc && drop_q != 16'hFFFF)
                drop_q <= drop_q + 16'd1;

            for (int i = 0; i < NSLOTS; i++) begin
                if (csr_wr && word == 10'(2 * i) && csr_di[1:0] != 2'd3)
                    state_q[i] <= csr_di[1:0];
                else if (finish && slot_q == SW'(i) && state_q[i] == ST_LOADED)
                    state_q[i] <= ST_PENDING;
                if (finish && slot_q == SW'(i))
                    count_q[i] <= bcnt_q;
            end

            case (rx_q)
                RX_IDLE: begin
                    if (rx_ce && phy_dv && phy_rx_data == 4'h5) rx_q <= RX_PRE;
                end
                RX_PRE: begin
                    if (rx_ce) begin
                        if (!phy_dv || (phy_rx_data != 4'h5 && phy_rx_data != 4'hD)) begin
                            rx_q <= RX_IDLE;
                        end else if (phy_rx_data == 4'hD) begin
                            if (found) begin
                                rx_q   <= RX_DATA;
                                slot_q <= pick;
                                bcnt_q <= '0;
                                half_q <= 1'b0;
                            end else begin
                                rx_q <= RX_DROP;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (abort) begin
                        rx_q <= RX_DROP;
                    end else if (finish) begin
                        rx_q <= RX_IDLE;
                        if (lane != 2'd0) begin
                            buf_we_q  <= 1'b1;
                            buf_adr_q <= {slot_q, bcnt_q[SLOT_AW+1:2]};
                            buf_dat_q <= word_q;
                        end
                    end else if (rx_byte) begin
                        half_q <= 1'b0;
                        bcnt_q <= bcnt_q + CW'(1);
                        case (lane)
                            2'd0: word_q <= {24'd0, byte_val};
                            2'd1: word_q[15:8]  <= byte_val;
                            2'd2: word_q[23:16] <= byte_val;
                            default: begin
                                word_q[31:24] <= byte_val;
                                buf_we_q      <= 1'b1;
                                buf_adr_q     <= {slot_q, bcnt_q[SLOT_AW+1:2]};
                                buf_dat_q     <= {byte_val, word_q[23:0]};
                            end
                        endcase
                    end else if (data_ev && phy_dv) begin
                        nib_q  <= phy_rx_data;
                        half_q <= 1'b1;
                    end
                end
                RX_DROP: begin
                    if (rx_ce && !phy_dv) rx_q <= RX_IDLE;
                end
                default: rx_q <= RX_IDLE;
            endcase
        end
    end

    assign csr_do  = csr_do_q;
    assign buf_we  = buf_we_q;
    assign buf_adr = buf_adr_q;
    assign buf_dat = buf_dat_q;
    assign irq_rx  = irq_q;

endmodule

// File: tb/tb_minimac_rx_slots.sv
// tb/tb_minimac_rx_slots.sv - self-checking bench for minimac_rx_slots with a frame-level reference model
`timescale 1ns/1ps
module tb_minimac_rx_slots;
    localparam int NSLOTS  = 4;
    localparam int SLOT_AW = 2;
    localparam int SW      = 2;
    localparam int AW      = SW + SLOT_AW;
    localparam int CAP     = 4 << SLOT_AW;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic          rx_ce = 1'b0, phy_dv = 1'b0, phy_rx_er = 1'b0;
    logic [3:0]    phy_rx_data = 4'd0;
    logic [13:0]   csr_a = 14'd0;
    logic          csr_we = 1'b0;
    logic [31:0]   csr_di = 32'd0;
    logic [31:0]   csr_do;
    logic          buf_we;
    logic [AW-1:0] buf_adr;
    logic [31:0]   buf_dat;
    logic          irq_rx;

    minimac_rx_slots #(.csr_addr(4'h0), .NSLOTS(NSLOTS), .SLOT_AW(SLOT_AW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_ce(rx_ce), .phy_dv(phy_dv),
        .phy_rx_er(phy_rx_er), .phy_rx_data(phy_rx_data), .csr_a(csr_a), .csr_we(csr_we),
        .csr_di(csr_di), .csr_do(csr_do), .buf_we(buf_we), .buf_adr(buf_adr),
        .buf_dat(buf_dat), .irq_rx(irq_rx)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [AW+31:0] got_wr[$];
    logic [AW+31:0] exp_wr[$];
    logic [7:0]     frame_q[$];
    logic [1:0]     m_state[NSLOTS];
    int             m_count[NSLOTS];
    int             m_drop;
    logic [31:0]    r_state[NSLOTS];
    logic [31:0]    r_count[NSLOTS];
    logic [31:0]    r_drop;

    always @(negedge sys_clk) if (buf_we) got_wr.push_back({buf_adr, buf_dat});

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge sys_clk);
        rx_ce = 1'b1; phy_dv = dv; phy_rx_er = er; phy_rx_data = d;
        @(negedge sys_clk);
        rx_ce = 1'b0;
    endtask

    task automatic csr_wr(input int w, input logic [31:0] d, input logic [3:0] bank);
        @(negedge sys_clk);
        csr_a = {bank, 10'(w)}; csr_we = 1'b1; csr_di = d;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input int w, input logic [3:0] bank, output logic [31:0] d);
        @(negedge sys_clk);
        csr_a = {bank, 10'(w)}; csr_we = 1'b0;
        @(negedge sys_clk);
        d = csr_do;
    endtask

    task automatic read_all();
        for (int i = 0; i < NSLOTS; i++) begin
            csr_rd(2 * i, 4'h0, r_state[i]);
            csr_rd(2 * i + 1, 4'h0, r_count[i]);
        end
        csr_rd(2 * NSLOTS, 4'h0, r_drop);
    endtask

    task automatic arm(input int s, input logic [1:0] v);
        csr_wr(2 * s, {30'd0, v}, 4'h0);
        if (v != 2'd3) m_state[s] = v;
    endtask

    task automatic rand_bytes(input int n);
        frame_q.delete();
        for (int k = 0; k < n; k++) frame_q.push_back(8'($urandom));
    endtask

    task automatic send_preamble();
        repeat (15) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
    endtask

    task automatic send_payload(input int from, input int to, input int er_at);
        for (int k = from; k < to; k++) begin
            nib(1'b1, k == er_at, frame_q[k][3:0]);
            nib(1'b1, k == er_at, frame_q[k][7:4]);
        end
    endtask

    task automatic send_end(input bit odd);
        if (odd) nib(1'b1, 1'b0, 4'h9);
        repeat (3) nib(1'b0, 1'b0, 4'h0);
    endtask

    task automatic send_frame(input int er_at, input bit odd);
        got_wr.delete();
        send_preamble();
        send_payload(0, frame_q.size(), er_at);
        send_end(odd);
    endtask

    // Frame-level outcome: which slot is claimed, which words land, and what the CSRs then hold.
    task automatic model_frame(input int er_at);
        int slot, n, stop;
        bit aborted;
        logic [31:0] w;
        exp_wr.delete();
        slot = -1;
        for (int i = NSLOTS - 1; i >= 0; i--) if (m_state[i] == 2'd1) slot = i;
        if (slot < 0) begin
            if (m_drop < 65535) m_drop++;
            return;
        end
        n = frame_q.size(); stop = n; aborted = 0;
        if (er_at >= 0 && er_at < stop) begin stop = er_at; aborted = 1; end
        if (stop > CAP) begin stop = CAP; aborted = 1; end
        for (int b = 0; b < stop; b += 4) begin
            if (aborted && b + 4 > stop) break;
            w = 32'd0;
            for (int k = 0; k < 4; k++) if (b + k < stop) w[8*k +: 8] = frame_q[b + k];
            exp_wr.push_back({SW'(slot), SLOT_AW'(b / 4), w});
        end
        if (aborted) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            m_state[slot] = 2'd2;
            m_count[slot] = n;
        end
    endtask

    task automatic test_reset();
        #1 sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_checks++;
        if ({csr_do, buf_we, buf_adr, buf_dat, irq_rx} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got csr_do=%h we=%b adr=%h dat=%h irq=%b expected all 0", csr_do, buf_we, buf_adr, buf_dat, irq_rx);
        end
        sys_rst_n = 1'b1;
        for (int i = 0; i < NSLOTS; i++) begin m_state[i] = 2'd0; m_count[i] = 0; end
        m_drop = 0;
        read_all();
        for (int i = 0; i < NSLOTS; i++) begin
            n_checks++;
            if (r_state[i] !== 32'd0 || r_count[i] !== 32'd0) begin
                n_fail++;
                $display("FAIL reset_slot%0d got state=%0d count=%0d expected 0/0", i, r_state[i], r_count[i]);
            end
        end
        n_checks++;
        if (r_drop !== 32'd0) begin n_fail++; $display("FAIL reset_drop got %0d expected 0", r_drop); end
    endtask

    task automatic test_single_frame();
        arm(0, 2'd1);
        frame_q = '{8'h21, 8'h43, 8'h65, 8'h87};
        model_frame(-1);
        send_frame(-1, 1'b0);
        n_checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {4'h0, 32'h87654321}) begin
            n_fail++;
            $display("FAIL single_write got n=%0d first=%h expected 1 write %h", got_wr.size(), got_wr.size() ? got_wr[0] : '0, {4'h0, 32'h87654321});
        end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd2 || r_count[0] !== 32'd4 || irq_rx !== 1'b1) begin
            n_fail++;
            $display("FAIL single_csr got state=%0d count=%0d irq=%b expected 2/4/1", r_state[0], r_count[0], irq_rx);
        end
    endtask

    task automatic test_partial_frame();
        for (int i = 0; i < NSLOTS; i++) arm(i, 2'd0);
        arm(1, 2'd1);
        arm(2, 2'd1);
        frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        model_frame(-1);
        got_wr.delete();
        send_preamble();
        send_payload(0, 3, -1);
        arm(0, 2'd1);
        send_payload(3, 6, -1);
        send_end(1'b1);
        n_checks++;
        if (got_wr.size() != 2 || got_wr[0] !== {4'h4, 32'h44332211} || got_wr[1] !== {4'h5, 32'h00006655}) begin
            n_fail++;
            $display("FAIL partial_writes got n=%0d w0=%h w1=%h expected %h %h", got_wr.size(), got_wr[0], got_wr[1], {4'h4, 32'h44332211}, {4'h5, 32'h00006655});
        end
        read_all();
        n_checks++;
        if (r_state[1] !== 32'd2 || r_count[1] !== 32'd6 || r_state[2] !== 32'd1 || r_state[0] !== 32'd1) begin
            n_fail++;
            $display("FAIL partial_csr got s0=%0d s1=%0d c1=%0d s2=%0d expected 1/2/6/1", r_state[0], r_state[1], r_count[1], r_state[2]);
        end
    endtask

    task automatic test_drop_counter();
        arm(0, 2'd0); arm(2, 2'd0); arm(3, 2'd0);
        @(negedge sys_clk);
        csr_a = {4'h0, 10'd2}; csr_we = 1'b1; csr_di = 32'd0;
        @(negedge sys_clk);
        csr_we = 1'b0;
        m_state[1] = 2'd0;
        n_checks++;
        if (irq_rx !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b expected 1", irq_rx); end
        @(negedge sys_clk);
        n_checks++;
        if (irq_rx !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b expected 0", irq_rx); end
        got_wr.delete();
        for (int f = 0; f < 3; f++) begin
            rand_bytes($urandom_range(1, 8));
            model_frame(-1);
            send_preamble();
            send_payload(0, frame_q.size(), -1);
            send_end(1'b0);
        end
        n_checks++;
        if (got_wr.size() != 0) begin n_fail++; $display("FAIL drop_nowrite got %0d writes expected 0", got_wr.size()); end
        csr_rd(2 * NSLOTS, 4'h0, r_drop);
        n_checks++;
        if (r_drop !== 32'd3) begin n_fail++; $display("FAIL drop_count got %0d expected 3", r_drop); end
        csr_wr(2 * NSLOTS, 32'h0000_1234, 4'h0);
        m_drop = 0;
        csr_rd(2 * NSLOTS, 4'h0, r_drop);
        n_checks++;
        if (r_drop !== 32'd0) begin n_fail++; $display("FAIL drop_clear got %0d expected 0", r_drop); end
    endtask

    task automatic test_rx_error();
        arm(0, 2'd1);
        rand_bytes(14);
        model_frame(10);
        send_frame(10, 1'b0);
        n_checks++;
        if (got_wr != exp_wr) begin n_fail++; $display("FAIL rxer_writes got n=%0d expected n=%0d", got_wr.size(), exp_wr.size()); end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd1 || r_count[0] !== 32'(m_count[0]) || r_drop !== 32'd1) begin
            n_fail++;
            $display("FAIL rxer_csr got state=%0d count=%0d drop=%0d expected 1/%0d/1", r_state[0], r_count[0], r_drop, m_count[0]);
        end
        rand_bytes(5);
        model_frame(-1);
        send_frame(-1, 1'b0);
        n_checks++;
        if (got_wr != exp_wr || got_wr.size() != 2) begin n_fail++; $display("FAIL rxer_next_writes got n=%0d expected 2", got_wr.size()); end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd2 || r_count[0] !== 32'd5) begin
            n_fail++;
            $display("FAIL rxer_next_csr got state=%0d count=%0d expected 2/5", r_state[0], r_count[0]);
        end
    endtask

    task automatic test_overflow();
        arm(0, 2'd1);
        rand_bytes(20);
        model_frame(-1);
        send_frame(-1, 1'b0);
        n_checks++;
        if (got_wr != exp_wr || got_wr.size() != 4 || got_wr[3][AW+31:32] !== 4'h3) begin
            n_fail++;
            $display("FAIL ovf_writes got n=%0d expected 4 ending at adr 3", got_wr.size());
        end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd1 || r_count[0] !== 32'd5 || r_drop !== 32'd2) begin
            n_fail++;
            $display("FAIL ovf_csr got state=%0d count=%0d drop=%0d expected 1/5/2", r_state[0], r_count[0], r_drop);
        end
    endtask

    task automatic test_sw_abort();
        rand_bytes(10);
        got_wr.delete();
        send_preamble();
        send_payload(0, 6, -1);
        arm(0, 2'd0);
        m_drop++;
        send_payload(6, 10, -1);
        send_end(1'b0);
        n_checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {4'h0, frame_q[3], frame_q[2], frame_q[1], frame_q[0]}) begin
            n_fail++;
            $display("FAIL swabort_writes got n=%0d expected 1", got_wr.size());
        end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd0 || r_count[0] !== 32'd5 || r_drop !== 32'd3) begin
            n_fail++;
            $display("FAIL swabort_csr got state=%0d count=%0d drop=%0d expected 0/5/3", r_state[0], r_count[0], r_drop);
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] other;
        bit exp_irq;
        int er_at, len;
        csr_wr(0, 32'd1, 4'h1);
        csr_rd(2 * NSLOTS, 4'h1, other);
        n_checks++;
        if (other !== 32'd0) begin n_fail++; $display("FAIL bank_select got %h expected 0", other); end
        for (int it = 0; it < 30; it++) begin
            for (int s = 0; s < NSLOTS; s++)
                if ($urandom_range(0, 3) == 0) arm(s, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) arm($urandom_range(0, NSLOTS - 1), 2'd1);
            if ($urandom_range(0, 7) == 0) begin csr_wr(2 * NSLOTS, 32'd0, 4'h0); m_drop = 0; end
            len = $urandom_range(1, 22);
            er_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
            rand_bytes(len);
            model_frame(er_at);
            send_frame(er_at, 1'($urandom_range(0, 1)));
            n_checks++;
            if (got_wr.size() != exp_wr.size()) begin
                n_fail++;
                $display("FAIL rand%0d_nwrites got %0d expected %0d", it, got_wr.size(), exp_wr.size());
            end else begin
                for (int k = 0; k < exp_wr.size(); k++) begin
                    n_checks++;
                    if (got_wr[k] !== exp_wr[k]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d got %h expected %h", it, k, got_wr[k], exp_wr[k]);
                    end
                end
            end
            read_all();
            exp_irq = 0;
            for (int i = 0; i < NSLOTS; i++) begin
                if (m_state[i] == 2'd2) exp_irq = 1;
                n_checks++;
                if (r_state[i] !== {30'd0, m_state[i]} || r_count[i] !== 32'(m_count[i])) begin
                    n_fail++;
                    $display("FAIL rand%0d_slot%0d got state=%0d count=%0d expected %0d/%0d", it, i, r_state[i], r_count[i], m_state[i], m_count[i]);
                end
            end
            n_checks++;
            if (r_drop !== 32'(m_drop) || irq_rx !== exp_irq) begin
                n_fail++;
                $display("FAIL rand%0d_drop_irq got drop=%0d irq=%b expected %0d/%b", it, r_drop, irq_rx, m_drop, exp_irq);
            end
        end
    endtask

    task automatic test_async_reset();
        arm(0, 2'd1);
        rand_bytes(6);
        got_wr.delete();
        send_preamble();
        send_payload(0, 3, -1);
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({csr_do, buf_we, buf_adr, buf_dat, irq_rx} !== '0) begin
            n_fail++;
            $display("FAIL async_reset_outputs got csr_do=%h we=%b adr=%h dat=%h irq=%b expected all 0", csr_do, buf_we, buf_adr, buf_dat, irq_rx);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < NSLOTS; i++) begin m_state[i] = 2'd0; m_count[i] = 0; end
        m_drop = 0;
        got_wr.delete();
        repeat (8) begin nib(1'b1, 1'b0, 4'hA); nib(1'b1, 1'b0, 4'h3); end
        send_end(1'b0);
        n_checks++;
        if (got_wr.size() != 0) begin n_fail++; $display("FAIL async_nowrite got %0d writes expected 0", got_wr.size()); end
        read_all();
        for (int i = 0; i < NSLOTS; i++) begin
            n_checks++;
            if (r_state[i] !== 32'd0) begin n_fail++; $display("FAIL async_slot%0d got %0d expected 0", i, r_state[i]); end
        end
        arm(0, 2'd1);
        frame_q = '{8'hA1, 8'hB2, 8'hC3};
        model_frame(-1);
        send_frame(-1, 1'b0);
        n_checks++;
        if (got_wr.size() != 1 || got_wr[0] !== {4'h0, 32'h00C3B2A1}) begin
            n_fail++;
            $display("FAIL async_fresh_write got n=%0d expected 1 write %h", got_wr.size(), {4'h0, 32'h00C3B2A1});
        end
        read_all();
        n_checks++;
        if (r_state[0] !== 32'd2 || r_count[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL async_fresh_csr got state=%0d count=%0d expected 2/3", r_state[0], r_count[0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_partial_frame();
        test_drop_counter();
        test_rx_error();
        test_overflow();
        test_sw_abort();
        test_random_frames();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
